// File: rtl/rv32_alu_rf_pkg.sv
// Shared widths and ALU operation codes for the RV32I integer datapath.
package rv32_alu_rf_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = $clog2(NREG);
  localparam int OP_W       = 5;

  // Code 0 is ADD so that a reset/bubble opcode turns into a harmless add.
  localparam logic [OP_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [OP_W-1:0] ALU_SLL  = 5'd2;
  localparam logic [OP_W-1:0] ALU_SLT  = 5'd3;
  localparam logic [OP_W-1:0] ALU_SLTU = 5'd4;
  localparam logic [OP_W-1:0] ALU_XOR  = 5'd5;
  localparam logic [OP_W-1:0] ALU_SRL  = 5'd6;
  localparam logic [OP_W-1:0] ALU_SRA  = 5'd7;
  localparam logic [OP_W-1:0] ALU_OR   = 5'd8;
  localparam logic [OP_W-1:0] ALU_AND  = 5'd9;

endpackage

// File: rtl/rv32_alu_rf_alu_core.sv
// Combinational R-type ALU; result is registered by the surrounding pipeline.
module rv32_alu_core
  import rv32_alu_rf_pkg::*;
#(
  parameter int DW = XLEN
) (
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  input  logic [OP_W-1:0] op_i,
  output logic [DW-1:0]   y_o
);

  logic [4:0] shamt;

  // Shifts only look at the low five bits of B.
  assign shamt = b_i[4:0];

  // Operation select; unused codes yield zero.
  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLL:  y_o = a_i << shamt;
      ALU_SLT:  y_o = {{(DW-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: y_o = {{(DW-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SRL:  y_o = a_i >> shamt;
      ALU_SRA:  y_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:   y_o = a_i | b_i;
      ALU_AND:  y_o = a_i & b_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32_alu_rf_regfile.sv
// Register file: NREG x XLEN storage, x0 hardwired to zero, async clear,
// and a write-through bypass so the ID read sees the same-cycle WB write.
module rv32_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   rnum1_i,
  output logic [XLEN-1:0] rdata1_o,
  input  logic [AW-1:0]   rnum2_i,
  output logic [XLEN-1:0] rdata2_o,
  input  logic [AW-1:0]   wnum_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [NREG];
  logic            wr_en;

  // WNUM=0 is the idle encoding, so there is no separate write enable.
  assign wr_en = (wnum_i != '0);

  // Storage: cleared asynchronously, written on the rising edge when rd != x0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wnum_i] <= wdata_i;
    end
  end

  // Read ports: x0 reads zero, a matching in-flight write is forwarded,
  // otherwise the stored value. The bypass holds even while reset is asserted.
  always_comb begin
    rdata1_o = regs_q[rnum1_i];
    if (rnum1_i == '0)                  rdata1_o = '0;
    else if (wr_en && rnum1_i == wnum_i) rdata1_o = wdata_i;

    rdata2_o = regs_q[rnum2_i];
    if (rnum2_i == '0)                  rdata2_o = '0;
    else if (wr_en && rnum2_i == wnum_i) rdata2_o = wdata_i;
  end

endmodule

// File: rtl/rv32_alu_rf.sv
// Integer datapath wrapper: register file and ALU side by side; the two
// are connected only to the top-level ports, never to each other.
module rv32_alu_rf #(
  parameter int XLEN = rv32_alu_rf_pkg::XLEN,
  parameter int NREG = rv32_alu_rf_pkg::NREG
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [$clog2(NREG)-1:0] RNUM1,
  output logic [XLEN-1:0]         RDATA1,
  input  logic [$clog2(NREG)-1:0] RNUM2,
  output logic [XLEN-1:0]         RDATA2,
  input  logic [$clog2(NREG)-1:0] WNUM,
  input  logic [XLEN-1:0]         WDATA,
  input  logic [XLEN-1:0]         A,
  input  logic [XLEN-1:0]         B,
  input  logic [4:0]              C,
  output logic [XLEN-1:0]         Y
);

  rv32_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk_i    (CLK),
    .rst_i    (RST),
    .rnum1_i  (RNUM1),
    .rdata1_o (RDATA1),
    .rnum2_i  (RNUM2),
    .rdata2_o (RDATA2),
    .wnum_i   (WNUM),
    .wdata_i  (WDATA)
  );

  rv32_alu_core #(.DW(XLEN)) u_alu (
    .a_i  (A),
    .b_i  (B),
    .op_i (C),
    .y_o  (Y)
  );

endmodule

// File: tb/tb_rv32_alu_rf.sv
// Bench for rv32_alu_rf: scoreboard of expected values, table-driven ALU
// vectors, and hand-written register file sequences.
module tb_rv32_alu_rf;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  RNUM1, RNUM2, WNUM, C;
  logic [31:0] RDATA1, RDATA2, WDATA, A, B, Y;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  rv32_alu_rf dut (
    .CLK(CLK), .RST(RST),
    .RNUM1(RNUM1), .RDATA1(RDATA1),
    .RNUM2(RNUM2), .RDATA2(RDATA2),
    .WNUM(WNUM), .WDATA(WDATA),
    .A(A), .B(B), .C(C), .Y(Y)
  );

  // Scoreboard entry: which output to look at and what it must be.
  typedef struct {
    string       name;
    int          src;   // 0=Y 1=RDATA1 2=RDATA2
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    string       name;
    logic [4:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;
  vec_t vecs[18];

  task automatic push(input string n, input int src, input logic [31:0] e);
    sb_t s;
    s.name = n; s.src = src; s.exp = e;
    sb.push_back(s);
  endtask

  task automatic drain();
    sb_t s;
    logic [31:0] act;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      act = (s.src == 0) ? Y : (s.src == 1) ? RDATA1 : RDATA2;
      checks++;
      if (act !== s.exp) begin
        errors++;
        $display("FAIL %s: got %08h expected %08h", s.name, act, s.exp);
      end
    end
  endtask

  task automatic step_check();
    @(negedge CLK);
    drain();
  endtask

  task automatic next_edge();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] pat(input int r);
    return 32'h01010101 * r ^ 32'h5A000000;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"add_wrap",   5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[1]  = '{"add_basic",  5'd0,  32'd7,        32'd5,        32'd12};
    vecs[2]  = '{"sub_wrap",   5'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF};
    vecs[3]  = '{"and",        5'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[4]  = '{"or",         5'd8,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0};
    vecs[5]  = '{"xor",        5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
    vecs[6]  = '{"slt_neg",    5'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    vecs[7]  = '{"sltu_neg",   5'd4,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[8]  = '{"slt_eq",     5'd3,  32'd5,        32'd5,        32'h00000000};
    vecs[9]  = '{"sltu_lt",    5'd4,  32'd1,        32'hFFFFFFFF, 32'h00000001};
    vecs[10] = '{"sll_31",     5'd2,  32'h00000001, 32'd31,       32'h80000000};
    vecs[11] = '{"srl_4",      5'd6,  32'h80000000, 32'd4,        32'h08000000};
    vecs[12] = '{"sra_4",      5'd7,  32'h80000000, 32'd4,        32'hF8000000};
    vecs[13] = '{"sra_pos",    5'd7,  32'h70000000, 32'd4,        32'h07000000};
    vecs[14] = '{"sll_b21",    5'd2,  32'h00000001, 32'h00000021, 32'h00000002};
    vecs[15] = '{"srl_bhi",    5'd6,  32'h12345678, 32'hFFFFFFE0, 32'h12345678};
    vecs[16] = '{"illegal15",  5'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[17] = '{"illegal10",  5'd10, 32'h00000001, 32'h00000001, 32'h00000000};

    RST = 1'b1; RNUM1 = 5'd1; RNUM2 = 5'd2; WNUM = 5'd0; WDATA = '0;
    A = '0; B = '0; C = 5'd0;

    // Reset state: stored reads zero, bubble opcode adds 0+0.
    push("rst_rdata1", 1, 32'h0);
    push("rst_rdata2", 2, 32'h0);
    push("rst_y",      0, 32'h0);
    step_check();
    next_edge();
    RST = 1'b0;

    // Fill x1..x31 with distinct patterns.
    for (int r = 1; r < 32; r++) begin
      WNUM = 5'(r); WDATA = pat(r);
      next_edge();
    end
    WNUM = 5'd0; RNUM1 = 5'd3; RNUM2 = 5'd31;
    push("fill_x3",  1, pat(3));
    push("fill_x31", 2, pat(31));
    step_check();

    // Asynchronous reset mid-cycle clears contents immediately.
    @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    push("async_rst_x3",  1, 32'h0);
    push("async_rst_x31", 2, 32'h0);
    drain();
    next_edge();
    RST = 1'b0;
    for (int r = 1; r < 32; r++) begin
      next_edge();
      RNUM1 = 5'(r); RNUM2 = 5'(32 - r);
      push($sformatf("clr_p1_x%0d", r), 1, 32'h0);
      push($sformatf("clr_p2_x%0d", 32 - r), 2, 32'h0);
      step_check();
    end

    // x0: attempted write is discarded, reads stay zero.
    next_edge();
    WNUM = 5'd0; WDATA = 32'hDEADBEEF; RNUM1 = 5'd0; RNUM2 = 5'd0;
    push("x0_same_cycle", 1, 32'h0);
    step_check();
    next_edge();
    push("x0_after_edge", 2, 32'h0);
    step_check();

    // Write x5, bypass in the same cycle, stored value afterwards.
    next_edge();
    WNUM = 5'd5; WDATA = 32'h12345678; RNUM1 = 5'd5; RNUM2 = 5'd6;
    push("bypass_x5_p1", 1, 32'h12345678);
    push("no_bypass_x6", 2, 32'h0);
    step_check();
    next_edge();
    WNUM = 5'd0; RNUM1 = 5'd5;
    push("stored_x5", 1, 32'h12345678);
    step_check();
    next_edge();
    WNUM = 5'd5; WDATA = 32'hCAFEF00D; RNUM1 = 5'd5; RNUM2 = 5'd5;
    push("bypass_both_p1", 1, 32'hCAFEF00D);
    push("bypass_both_p2", 2, 32'hCAFEF00D);
    step_check();
    next_edge();
    WNUM = 5'd0; RNUM2 = 5'd0;
    push("overwritten_x5", 1, 32'hCAFEF00D);
    push("x0_read_p2",     2, 32'h0);
    step_check();

    // Bypass still applies while reset is held; the write itself is lost.
    next_edge();
    RST = 1'b1; WNUM = 5'd9; WDATA = 32'hA5A5A5A5; RNUM1 = 5'd9; RNUM2 = 5'd5;
    push("rst_bypass_x9", 1, 32'hA5A5A5A5);
    push("rst_clear_x5",  2, 32'h0);
    step_check();
    next_edge();
    RST = 1'b0; WNUM = 5'd0;
    push("rst_no_write_x9", 1, 32'h0);
    step_check();

    // ALU table.
    foreach (vecs[i]) begin
      next_edge();
      A = vecs[i].a; B = vecs[i].b; C = vecs[i].c;
      push(vecs[i].name, 0, vecs[i].y);
      step_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
